// File: rtl/m68k_bus_target.sv
// 68000-bus target: answers Amiga bus cycles that fall inside an address window
// by forwarding them to a local backend over a req/ack handshake.
module m68k_bus_target #(
  parameter logic [23:0] BASE_ADDR   = 24'hE80000,
  parameter int          WINDOW_BITS = 16,
  parameter int          TIMEOUT     = 255
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   as_n_in,
  input  logic                   uds_n_in,
  input  logic                   lds_n_in,
  input  logic                   rnw_in,
  input  logic [2:0]             fc_in,
  input  logic [23:1]            a_in,
  input  logic [15:0]            d_in,
  output logic [15:0]            d_out,
  output logic                   d_oe,
  output logic                   dtack_oe,
  output logic                   berr_oe,
  output logic                   be_req,
  output logic                   be_we,
  output logic [WINDOW_BITS-2:0] be_addr,
  output logic [1:0]             be_be,
  output logic [15:0]            be_wdata,
  input  logic                   be_ack,
  input  logic [15:0]            be_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_MISS, S_WAIT_DS, S_REQ, S_DRIVE, S_ACK, S_ERR
  } state_t;

  state_t        state_q;
  logic [3:0]    sync1_q, sync2_q;   // {as, uds, lds, rnw}
  logic          as_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          as_s, uds_s, lds_s, rnw_s, ds_low, hit;

  assign as_s   = sync2_q[3];
  assign uds_s  = sync2_q[2];
  assign lds_s  = sync2_q[1];
  assign rnw_s  = sync2_q[0];
  assign ds_low = ~uds_s | ~lds_s;
  // CPU-space (fc=7) cycles are never claimed, even inside the window.
  assign hit    = (a_in[23:WINDOW_BITS] == BASE_ADDR[23:WINDOW_BITS]) && (fc_in != 3'b111);
  assign cnt_d  = (cnt_q == TMAX) ? cnt_q : cnt_q + CW'(1);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      as_prev_q <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      d_out     <= '0;
      d_oe      <= 1'b0;
      dtack_oe  <= 1'b0;
      berr_oe   <= 1'b0;
      be_req    <= 1'b0;
      be_we     <= 1'b0;
      be_addr   <= '0;
      be_be     <= '0;
      be_wdata  <= '0;
    end else begin
      sync1_q   <= {as_n_in, uds_n_in, lds_n_in, rnw_in};
      sync2_q   <= sync1_q;
      as_prev_q <= as_s;
      case (state_q)
        S_IDLE: begin
          // Address and FC are stable by the time the synchronised AS falls.
          if (as_prev_q && !as_s) begin
            be_addr <= a_in[WINDOW_BITS-1:1];
            state_q <= hit ? S_WAIT_DS : S_MISS;
          end
        end
        S_MISS: begin
          if (as_s) state_q <= S_IDLE;
        end
        S_WAIT_DS: begin
          if (as_s) begin
            state_q <= S_IDLE;
          end else if (ds_low) begin
            be_be  <= {~uds_s, ~lds_s};
            if (!rnw_s) be_wdata <= d_in;
            be_we   <= ~rnw_s;
            be_req  <= 1'b1;
            cnt_q   <= '0;
            state_q <= S_REQ;
          end
        end
        S_REQ: begin
          cnt_q <= cnt_d;
          // Priority: AS release (abort) > ack > timeout.
          if (as_s) begin
            be_req  <= 1'b0;
            state_q <= S_IDLE;
          end else if (be_ack) begin
            be_req <= 1'b0;
            if (be_we) begin
              dtack_oe <= 1'b1;
              state_q  <= S_ACK;
            end else begin
              d_out   <= be_rdata;
              d_oe    <= 1'b1;
              state_q <= S_DRIVE;
            end
          end else if (cnt_d == TMAX) begin
            be_req  <= 1'b0;
            berr_oe <= 1'b1;
            state_q <= S_ERR;
          end
        end
        S_DRIVE: begin
          if (as_s) begin
            d_oe    <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            dtack_oe <= 1'b1;
            state_q  <= S_ACK;
          end
        end
        S_ACK: begin
          if (as_s) begin
            dtack_oe <= 1'b0;
            d_oe     <= 1'b0;
            state_q  <= S_IDLE;
          end
        end
        S_ERR: begin
          if (as_s) begin
            berr_oe <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m68k_bus_target.sv
// Directed bench for m68k_bus_target: expected backend requests are queued when a
// bus cycle is started and checked when the DUT raises be_req.
module tb_m68k_bus_target;

  logic        clk = 1'b0;
  logic        rst;
  logic        as_n, uds_n, lds_n, rnw;
  logic [2:0]  fc;
  logic [23:1] a;
  logic [15:0] d;
  logic [15:0] d_out;
  logic        d_oe, dtack_oe, berr_oe, be_req, be_we;
  logic [14:0] be_addr;
  logic [1:0]  be_be;
  logic [15:0] be_wdata;
  logic        be_ack;
  logic [15:0] be_rdata;

  typedef struct {
    logic        we;
    logic [14:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  m68k_bus_target #(
    .BASE_ADDR  (24'hE80000),
    .WINDOW_BITS(16),
    .TIMEOUT    (8)
  ) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .as_n_in (as_n),
    .uds_n_in(uds_n),
    .lds_n_in(lds_n),
    .rnw_in  (rnw),
    .fc_in   (fc),
    .a_in    (a),
    .d_in    (d),
    .d_out   (d_out),
    .d_oe    (d_oe),
    .dtack_oe(dtack_oe),
    .berr_oe (berr_oe),
    .be_req  (be_req),
    .be_we   (be_we),
    .be_addr (be_addr),
    .be_be   (be_be),
    .be_wdata(be_wdata),
    .be_ack  (be_ack),
    .be_rdata(be_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic start_cycle(input logic [23:0] addr, input logic [2:0] f, input logic r,
                             input logic u_n, input logic l_n, input logic [15:0] data);
    a     = addr[23:1];
    fc    = f;
    rnw   = r;
    d     = data;
    as_n  = 1'b0;
    uds_n = u_n;
    lds_n = l_n;
  endtask

  task automatic release_bus();
    as_n  = 1'b1;
    uds_n = 1'b1;
    lds_n = 1'b1;
    rnw   = 1'b1;
  endtask

  // Waits (bounded) for be_req, checks the request latency and pops the scoreboard.
  task automatic wait_req(input string tag, output exp_t e);
    int n = 0;
    e = '{1'b0, 15'h0, 2'b00, 16'h0, 16'h0};
    while (!be_req && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_req_latency"}, n, 4);
    if (be_req) begin
      chk({tag, "_sb_depth"}, sb.size(), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({tag, "_we"}, be_we, e.we);
        chk({tag, "_addr"}, be_addr, e.addr);
        chk({tag, "_be"}, be_be, e.be);
        if (e.we) chk({tag, "_wdata"}, be_wdata, e.wdata);
      end
    end
  endtask

  // Runs a bus cycle that must not be claimed and checks nothing is driven.
  task automatic run_quiet(input string tag, input logic [23:0] addr, input logic [2:0] f);
    logic act = 1'b0;
    start_cycle(addr, f, 1'b1, 1'b0, 1'b0, 16'h0);
    repeat (14) begin
      tick();
      act |= be_req | dtack_oe | berr_oe | d_oe;
    end
    release_bus();
    repeat (4) begin
      tick();
      act |= be_req | dtack_oe | berr_oe | d_oe;
    end
    chk(tag, act, 1'b0);
  endtask

  initial begin
    exp_t e;
    logic act;
    rst = 1'b1; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rnw = 1'b1;
    fc = 3'd0; a = '0; d = '0; be_ack = 1'b0; be_rdata = '0;
    repeat (2) tick();
    chk("reset_outs", {d_out, d_oe, dtack_oe, berr_oe, be_req, be_we, be_be}, 32'h0);
    chk("reset_addr", be_addr, 15'h0);
    chk("reset_wdata", be_wdata, 16'h0);
    rst = 1'b0;
    repeat (3) tick();

    // Word read at 0xE80010, ack three cycles after the request.
    sb.push_back('{1'b0, 15'h0008, 2'b11, 16'h0000, 16'hBEEF});
    start_cycle(24'hE80010, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0);
    wait_req("rd", e);
    tick(); tick();
    chk("rd_req_held", {be_req, d_oe, dtack_oe}, 3'b100);
    be_ack = 1'b1; be_rdata = e.rdata;
    tick();
    be_ack = 1'b0; be_rdata = 16'h0;
    chk("rd_doe_first", {be_req, d_oe, dtack_oe}, 3'b010);
    chk("rd_data", d_out, 16'hBEEF);
    tick();
    chk("rd_dtack", {d_oe, dtack_oe}, 2'b11);
    release_bus();
    tick(); tick();
    chk("rd_release_hold", {d_oe, dtack_oe}, 2'b11);
    tick();
    chk("rd_release", {d_oe, dtack_oe}, 2'b00);
    repeat (3) tick();

    // Byte write at 0xE80003, LDS only.
    sb.push_back('{1'b1, 15'h0001, 2'b01, 16'h00A5, 16'h0});
    start_cycle(24'hE80003, 3'd5, 1'b0, 1'b1, 1'b0, 16'h00A5);
    wait_req("wr", e);
    tick();
    chk("wr_pre_ack", {dtack_oe, d_oe}, 2'b00);
    be_ack = 1'b1;
    tick();
    be_ack = 1'b0;
    chk("wr_dtack", {be_req, dtack_oe, d_oe}, 3'b010);
    release_bus();
    tick(); tick();
    chk("wr_release_hold", {dtack_oe, d_oe}, 2'b10);
    tick();
    chk("wr_release", {dtack_oe, d_oe}, 2'b00);
    repeat (3) tick();

    // Out-of-window address and CPU-space cycle.
    run_quiet("miss_addr", 24'hF00000, 3'd5);
    run_quiet("miss_fc7", 24'hE80010, 3'd7);

    // Timeout: no ack for 8 cycles after the request.
    sb.push_back('{1'b0, 15'h0010, 2'b11, 16'h0, 16'h0});
    start_cycle(24'hE80020, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0);
    wait_req("to", e);
    repeat (7) tick();
    chk("to_before", {be_req, berr_oe}, 2'b10);
    tick();
    chk("to_fire", {be_req, berr_oe}, 2'b01);
    repeat (3) tick();
    chk("to_hold", berr_oe, 1'b1);
    be_ack = 1'b1;
    tick();
    be_ack = 1'b0;
    chk("to_late_ack", {dtack_oe, d_oe, berr_oe}, 3'b001);
    release_bus();
    tick(); tick();
    chk("to_release_hold", berr_oe, 1'b1);
    tick();
    chk("to_release", berr_oe, 1'b0);
    repeat (3) tick();

    // Abort: AS released while the request is outstanding.
    sb.push_back('{1'b0, 15'h0020, 2'b11, 16'h0, 16'h0});
    start_cycle(24'hE80040, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0);
    wait_req("ab", e);
    release_bus();
    tick(); tick();
    chk("ab_req_held", be_req, 1'b1);
    tick();
    chk("ab_req_drop", be_req, 1'b0);
    be_ack = 1'b1;
    tick();
    be_ack = 1'b0;
    act = 1'b0;
    repeat (12) begin
      tick();
      act |= dtack_oe | berr_oe | d_oe | be_req;
    end
    chk("ab_quiet", act, 1'b0);

    // Ack on the same edge as the timeout terminal count.
    sb.push_back('{1'b0, 15'h0080, 2'b11, 16'h0, 16'h1234});
    start_cycle(24'hE80100, 3'd6, 1'b1, 1'b0, 1'b0, 16'h0);
    wait_req("tc", e);
    repeat (7) tick();
    be_ack = 1'b1; be_rdata = e.rdata;
    tick();
    be_ack = 1'b0; be_rdata = 16'h0;
    chk("tc_ack_wins", {d_oe, berr_oe, be_req}, 3'b100);
    chk("tc_data", d_out, 16'h1234);
    tick();
    chk("tc_dtack", {dtack_oe, berr_oe}, 2'b10);
    release_bus();
    repeat (3) tick();
    chk("tc_release", {dtack_oe, d_oe, berr_oe}, 3'b000);
    repeat (3) tick();

    // Asynchronous reset while the request is outstanding.
    sb.push_back('{1'b0, 15'h0008, 2'b11, 16'h0, 16'h0});
    start_cycle(24'hE80010, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0);
    wait_req("rst", e);
    #1 rst = 1'b1;
    #1;
    chk("rst_async", {d_out, d_oe, dtack_oe, berr_oe, be_req, be_we, be_be}, 32'h0);
    chk("rst_async_addr", be_addr, 15'h0);
    release_bus();
    tick(); tick();
    rst = 1'b0;
    act = 1'b0;
    repeat (10) begin
      tick();
      act |= be_req | dtack_oe | berr_oe | d_oe;
    end
    chk("rst_idle_quiet", act, 1'b0);

    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
